// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master controller.
//   state_t : transaction sequencer states
//   phase_t : quarter of the current SCL bit period
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK1,
        ST_DATA,
        ST_ACK2,
        ST_STOP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } phase_t;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period tick generator for the I2C bit timing.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   en    : count enable; counter and phase are held at zero while low
//   tick  : one-clk pulse on the last clk of each SCL quarter
//   phase : current quarter Q0..Q3, advances on every tick
module i2c_qtick_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output logic   tick,
    output phase_t phase
);

    localparam int unsigned      CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (!en) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase_t'(phase + 2'd1);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: one command runs START, address+R/W, ACK,
// one data byte, ACK, STOP, then reports status on a one-clk response pulse.
//   clk, rst            : system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready while idle)
//   cmd_addr/rw/wdata   : target address, 0=write 1=read, write byte
//   rsp_valid           : one-clk pulse when the transaction has finished
//   rsp_nack/rsp_rdata  : status and read byte, held until the next response
//   busy                : transaction in progress
//   scl_oe/sda_oe       : open-drain pull-down enables (1 = pull low)
//   sda_i               : sampled SDA line level
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_rw,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_nack,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              scl_oe,
    output logic              sda_oe,
    input  logic              sda_i
);

    state_t            state, state_nxt;
    phase_t            phase;
    logic              tick;
    logic              bit_end;
    logic              accept;
    logic              bit_scl_low;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] addr_sr;
    logic [DATA_W-1:0] wdata_sr;
    logic [DATA_W-1:0] rdata_sr;
    logic              rw_q;
    logic              nack_q;
    logic              sda_smp;
    logic              scl_d;
    logic              sda_d;

    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = ~cmd_ready;
    assign rsp_valid   = (state == ST_DONE);
    assign accept      = cmd_ready && cmd_valid;
    assign bit_end     = tick && (phase == Q3);
    assign bit_scl_low = (phase == Q0) || (phase == Q3);

    i2c_qtick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_qtick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .tick (tick),
        .phase(phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus levels are decoded here and registered below, so SCL and SDA
    // move one clk after the phase change, always on separate quarters.
    always_comb begin
        state_nxt = state;
        scl_d     = 1'b0;
        sda_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) state_nxt = ST_START;
            end
            ST_START: begin
                scl_d = (phase == Q2) || (phase == Q3);
                sda_d = (phase != Q0);
                if (bit_end) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                scl_d = bit_scl_low;
                sda_d = ~addr_sr[DATA_W-1];
                if (bit_end && (bit_cnt == '0)) state_nxt = ST_ACK1;
            end
            ST_ACK1: begin
                scl_d = bit_scl_low;
                if (bit_end) state_nxt = sda_smp ? ST_STOP : ST_DATA;
            end
            ST_DATA: begin
                scl_d = bit_scl_low;
                sda_d = ~rw_q & ~wdata_sr[DATA_W-1];
                if (bit_end && (bit_cnt == '0)) state_nxt = ST_ACK2;
            end
            ST_ACK2: begin
                scl_d = bit_scl_low;
                if (bit_end) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                scl_d = (phase == Q0);
                sda_d = (phase == Q0) || (phase == Q1);
                if (bit_end) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // SDA is captured mid-bit (end of q1) and consumed at the end of q3.
    // The bit counter's natural 0 -> 7 wrap re-arms it for the next byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_sr  <= '0;
            wdata_sr <= '0;
            rdata_sr <= '0;
            rw_q     <= 1'b0;
            nack_q   <= 1'b0;
            sda_smp  <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            if (accept) begin
                addr_sr  <= {cmd_addr, cmd_rw};
                wdata_sr <= cmd_wdata;
                rdata_sr <= '0;
                rw_q     <= cmd_rw;
                nack_q   <= 1'b0;
                bit_cnt  <= 3'd7;
            end
            if (tick && (phase == Q1)) begin
                sda_smp <= sda_i;
            end
            if (bit_end) begin
                case (state)
                    ST_ADDR: begin
                        addr_sr <= {addr_sr[DATA_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                    ST_DATA: begin
                        wdata_sr <= {wdata_sr[DATA_W-2:0], 1'b0};
                        if (rw_q) rdata_sr <= {rdata_sr[DATA_W-2:0], sda_smp};
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                    ST_ACK1: nack_q <= sda_smp;
                    ST_ACK2: nack_q <= ~rw_q & sda_smp;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            rsp_nack  <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            scl_oe <= scl_d;
            sda_oe <= sda_d;
            if ((state == ST_STOP) && bit_end) begin
                rsp_nack  <= nack_q;
                rsp_rdata <= (rw_q && !nack_q) ? rdata_sr : '0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
module tb_i2c_master_ctrl;

    localparam int unsigned CLK_DIV = 4;
    localparam logic [6:0]  P_ADDR  = 7'h2A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_addr = '0;
    logic       cmd_rw = 1'b0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic       rsp_nack;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i;

    logic       scl_bus;
    logic       sda_bus;

    // peripheral model state
    logic       p_pull = 1'b0;
    logic       p_active = 1'b0;
    logic       p_match = 1'b0;
    logic       p_rw = 1'b0;
    logic [7:0] p_sr = '0;
    int         p_bit = 0;
    int         p_byte = 0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       bit_log[$];
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic [7:0] p_tx = '0;
    logic       p_nack_data = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_rw   (cmd_rw),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_nack (rsp_nack),
        .rsp_rdata(rsp_rdata),
        .busy     (busy),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .sda_i    (sda_i)
    );

    always #5 clk = ~clk;

    assign scl_bus = ~scl_oe;
    assign sda_bus = ~(sda_oe | p_pull);
    assign sda_i   = sda_bus;

    // Behavioural peripheral at P_ADDR, driven purely by bus edges.
    always @(scl_bus or sda_bus or rst) begin
        if (rst) begin
            p_active = 1'b0;
            p_pull   = 1'b0;
        end else if (scl_bus && prev_scl && (sda_bus != prev_sda)) begin
            if (!sda_bus) begin
                start_cnt++;
                p_active = 1'b1;
                p_bit    = 0;
                p_byte   = 0;
                p_match  = 1'b0;
                bit_log.delete();
            end else begin
                stop_cnt++;
                p_active = 1'b0;
            end
            p_pull = 1'b0;
        end else if (scl_bus && !prev_scl) begin
            if (p_active && p_byte < 2) begin
                bit_log.push_back(sda_bus);
                p_sr = {p_sr[6:0], sda_bus};
                p_bit++;
            end
        end else if (!scl_bus && prev_scl && p_active) begin
            if (p_bit == 8) begin
                if (p_byte == 0) begin
                    p_match = (p_sr[7:1] == P_ADDR);
                    p_rw    = p_sr[0];
                    p_pull  = p_match;
                end else if (!p_rw) begin
                    p_pull = !p_nack_data;
                end else begin
                    p_pull = 1'b0;
                end
            end else if (p_bit == 9) begin
                p_bit  = 0;
                p_byte++;
                p_pull = 1'b0;
                if (!p_match) p_active = 1'b0;
                else if (p_byte == 1 && p_rw) p_pull = !p_tx[7];
            end else if (p_bit >= 1 && p_byte == 1 && p_rw && p_match) begin
                p_pull = !p_tx[7-p_bit];
            end
        end
        prev_scl = scl_bus;
        prev_sda = sda_bus;
    end

    // Reference: expected SDA bit sequence seen on SCL rising, status, latency.
    task automatic model_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                             input logic [7:0] tx, input logic dnack,
                             output logic nk, output logic [7:0] rd,
                             output logic [31:0] bits, output int nbits, output int lat);
        logic [7:0] hdr;
        logic [7:0] dat;
        logic       ack_ok;
        hdr    = {a, rw};
        ack_ok = (a == P_ADDR);
        bits   = '0;
        nbits  = 0;
        for (int i = 7; i >= 0; i--) begin
            bits = {bits[30:0], hdr[i]};
            nbits++;
        end
        bits = {bits[30:0], !ack_ok};
        nbits++;
        if (ack_ok) begin
            dat = rw ? tx : wd;
            for (int i = 7; i >= 0; i--) begin
                bits = {bits[30:0], dat[i]};
                nbits++;
            end
            bits = {bits[30:0], (rw ? 1'b1 : dnack)};
            nbits++;
        end
        nk  = !ack_ok || (!rw && dnack);
        rd  = (ack_ok && rw) ? tx : 8'h00;
        lat = (nbits + 2) * 4 * int'(CLK_DIV);
    endtask

    // Drives one command and measures the outcome; no judging here.
    task automatic send_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                            output int lat, output logic nk, output logic [7:0] rd,
                            output logic [31:0] bits, output int nbits,
                            output int pulse_len, output int n_start, output int n_stop);
        int s0;
        int t0;
        int guard;
        s0 = start_cnt;
        t0 = stop_cnt;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_wdata = wd;
        guard = 0;
        while (!cmd_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = 7'($urandom());
        cmd_rw    = 1'($urandom());
        cmd_wdata = 8'($urandom());
        lat = 0;
        while (!rsp_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        nk = rsp_nack;
        rd = rsp_rdata;
        pulse_len = 0;
        while (rsp_valid && pulse_len < 10) begin
            pulse_len++;
            @(posedge clk);
            #1;
        end
        bits = '0;
        foreach (bit_log[i]) bits = {bits[30:0], bit_log[i]};
        nbits   = bit_log.size();
        n_start = start_cnt - s0;
        n_stop  = stop_cnt - t0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, busy, rsp_valid, rsp_nack, rsp_rdata, scl_oe, sda_oe} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b busy=%b rv=%b nk=%b rd=%h scl=%b sda=%b want 1 0 0 0 00 0 0",
                     cmd_ready, busy, rsp_valid, rsp_nack, rsp_rdata, scl_oe, sda_oe);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, busy, scl_oe, sda_oe} !== 4'b1000) begin
            n_fail++;
            $display("FAIL idle_after_reset got rdy=%b busy=%b scl=%b sda=%b want 1 0 0 0", cmd_ready, busy, scl_oe, sda_oe);
        end
    endtask

    task automatic test_write();
        logic nk, enk;
        logic [7:0] rd, erd;
        logic [31:0] bits, ebits;
        int nb, enb, lat, elat, pl, ns, np;
        p_tx = 8'h00;
        p_nack_data = 1'b0;
        model_txn(7'h2A, 1'b0, 8'hA5, p_tx, p_nack_data, enk, erd, ebits, enb, elat);
        send_cmd(7'h2A, 1'b0, 8'hA5, lat, nk, rd, bits, nb, pl, ns, np);
        n_cmp++;
        if (lat !== 320 || elat !== 320) begin
            n_fail++;
            $display("FAIL write_latency got %0d want 320", lat);
        end
        n_cmp++;
        if (nb !== enb || bits !== ebits) begin
            n_fail++;
            $display("FAIL write_bus_bits got %0d:%h want %0d:%h", nb, bits, enb, ebits);
        end
        n_cmp++;
        if ({nk, rd} !== {enk, erd} || pl !== 1) begin
            n_fail++;
            $display("FAIL write_rsp got nack=%b rdata=%h pulse=%0d want nack=%b rdata=%h pulse=1", nk, rd, pl, enk, erd);
        end
        n_cmp++;
        if (ns !== 1 || np !== 1) begin
            n_fail++;
            $display("FAIL write_start_stop got %0d/%0d want 1/1", ns, np);
        end
    endtask

    task automatic test_read();
        logic nk, enk;
        logic [7:0] rd, erd;
        logic [31:0] bits, ebits;
        int nb, enb, lat, elat, pl, ns, np;
        p_tx = 8'h3C;
        p_nack_data = 1'b0;
        model_txn(7'h2A, 1'b1, 8'h00, p_tx, p_nack_data, enk, erd, ebits, enb, elat);
        send_cmd(7'h2A, 1'b1, 8'h00, lat, nk, rd, bits, nb, pl, ns, np);
        n_cmp++;
        if (rd !== 8'h3C || nk !== 1'b0 || pl !== 1) begin
            n_fail++;
            $display("FAIL read_rsp got rdata=%h nack=%b pulse=%0d want rdata=3c nack=0 pulse=1", rd, nk, pl);
        end
        n_cmp++;
        if (nb !== enb || bits !== ebits || lat !== elat) begin
            n_fail++;
            $display("FAIL read_bus_bits got %0d:%h lat=%0d want %0d:%h lat=%0d", nb, bits, lat, enb, ebits, elat);
        end
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (rsp_rdata !== 8'h3C || rsp_nack !== 1'b0) begin
            n_fail++;
            $display("FAIL read_hold got rdata=%h nack=%b want 3c 0", rsp_rdata, rsp_nack);
        end
    endtask

    task automatic test_addr_nack();
        logic nk;
        logic [7:0] rd;
        logic [31:0] bits;
        int nb, lat, pl, ns, np;
        send_cmd(7'h11, 1'b0, 8'h5A, lat, nk, rd, bits, nb, pl, ns, np);
        n_cmp++;
        if (lat !== 176) begin
            n_fail++;
            $display("FAIL addr_nack_latency got %0d want 176", lat);
        end
        n_cmp++;
        if (nk !== 1'b1 || rd !== 8'h00) begin
            n_fail++;
            $display("FAIL addr_nack_rsp got nack=%b rdata=%h want 1 00", nk, rd);
        end
        n_cmp++;
        if (nb !== 9 || bits[8:0] !== 9'b0010_0010_1 || ns !== 1 || np !== 1) begin
            n_fail++;
            $display("FAIL addr_nack_bus got %0d:%h st=%0d sp=%0d want 9:045 1 1", nb, bits, ns, np);
        end
    endtask

    task automatic test_data_nack();
        logic nk, enk;
        logic [7:0] rd, erd;
        logic [31:0] bits, ebits;
        int nb, enb, lat, elat, pl, ns, np;
        p_nack_data = 1'b1;
        model_txn(7'h2A, 1'b0, 8'hC3, p_tx, p_nack_data, enk, erd, ebits, enb, elat);
        send_cmd(7'h2A, 1'b0, 8'hC3, lat, nk, rd, bits, nb, pl, ns, np);
        p_nack_data = 1'b0;
        n_cmp++;
        if (nk !== 1'b1 || rd !== 8'h00 || lat !== elat) begin
            n_fail++;
            $display("FAIL data_nack_rsp got nack=%b rdata=%h lat=%0d want 1 00 %0d", nk, rd, lat, elat);
        end
        n_cmp++;
        if (np !== 1 || nb !== enb || bits !== ebits) begin
            n_fail++;
            $display("FAIL data_nack_bus got stops=%0d %0d:%h want 1 %0d:%h", np, nb, bits, enb, ebits);
        end
    endtask

    task automatic test_random();
        logic nk, enk, rw, dn;
        logic [6:0] a;
        logic [7:0] wd, rd, erd;
        logic [31:0] bits, ebits;
        int nb, enb, lat, elat, pl, ns, np;
        for (int k = 0; k < 8; k++) begin
            a  = ($urandom_range(3, 0) != 0) ? P_ADDR : 7'($urandom());
            rw = 1'($urandom());
            wd = 8'($urandom());
            dn = ($urandom_range(3, 0) == 0);
            p_tx = 8'($urandom());
            p_nack_data = dn;
            model_txn(a, rw, wd, p_tx, dn, enk, erd, ebits, enb, elat);
            send_cmd(a, rw, wd, lat, nk, rd, bits, nb, pl, ns, np);
            n_cmp++;
            if ({nk, rd} !== {enk, erd} || lat !== elat || pl !== 1) begin
                n_fail++;
                $display("FAIL random_rsp[%0d] a=%h rw=%b got nack=%b rdata=%h lat=%0d pulse=%0d want %b %h %0d 1",
                         k, a, rw, nk, rd, lat, pl, enk, erd, elat);
            end
            n_cmp++;
            if (nb !== enb || bits !== ebits || ns !== 1 || np !== 1) begin
                n_fail++;
                $display("FAIL random_bus[%0d] got %0d:%h st=%0d sp=%0d want %0d:%h 1 1", k, nb, bits, ns, np, enb, ebits);
            end
        end
        p_nack_data = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic nk, enk;
        logic [7:0] rd, erd;
        logic [31:0] bits, ebits;
        int nb, enb, lat, elat, pl, ns, np, seen;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = P_ADDR;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'h96;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (229) @(posedge clk);
        #2;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy got %b want 1", busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({scl_oe, sda_oe, cmd_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got scl=%b sda=%b rdy=%b rv=%b rd=%h want 0 0 1 0 00",
                     scl_oe, sda_oe, cmd_ready, rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_rsp got %0d pulses want 0", seen);
        end
        model_txn(P_ADDR, 1'b0, 8'h3E, p_tx, 1'b0, enk, erd, ebits, enb, elat);
        send_cmd(P_ADDR, 1'b0, 8'h3E, lat, nk, rd, bits, nb, pl, ns, np);
        n_cmp++;
        if (nk !== enk || lat !== elat || nb !== enb || bits !== ebits) begin
            n_fail++;
            $display("FAIL reset_mid_recover got nack=%b lat=%0d %0d:%h want %b %0d %0d:%h", nk, lat, nb, bits, enk, elat, enb, ebits);
        end
    endtask

    task automatic test_back_to_back();
        logic nk1, enk2;
        logic [7:0] erd2;
        logic [31:0] bits, ebits;
        int enb, elat, lat, guard, n_idle, s0, t0, nb;
        p_tx = 8'($urandom());
        p_nack_data = 1'b0;
        s0 = start_cnt;
        t0 = stop_cnt;
        model_txn(P_ADDR, 1'b1, 8'h00, p_tx, 1'b0, enk2, erd2, ebits, enb, elat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = P_ADDR;
        cmd_rw    = 1'b0;
        cmd_wdata = 8'($urandom());
        @(posedge clk);
        #1;
        cmd_rw = 1'b1;
        guard = 0;
        while (!rsp_valid && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        nk1 = rsp_nack;
        n_idle = 0;
        @(posedge clk);
        #1;
        while (cmd_ready && n_idle < 50) begin
            n_idle++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (n_idle !== 1 || nk1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap got idle=%0d nack1=%b want 1 0", n_idle, nk1);
        end
        lat = 0;
        while (!rsp_valid && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bits = '0;
        foreach (bit_log[i]) bits = {bits[30:0], bit_log[i]};
        nb = bit_log.size();
        n_cmp++;
        if (rsp_rdata !== erd2 || rsp_nack !== enk2 || lat !== elat) begin
            n_fail++;
            $display("FAIL b2b_second_rsp got rdata=%h nack=%b lat=%0d want %h %b %0d", rsp_rdata, rsp_nack, lat, erd2, enk2, elat);
        end
        n_cmp++;
        if (nb !== enb || bits !== ebits || (start_cnt - s0) !== 2 || (stop_cnt - t0) !== 2) begin
            n_fail++;
            $display("FAIL b2b_bus got %0d:%h st=%0d sp=%0d want %0d:%h 2 2", nb, bits, start_cnt - s0, stop_cnt - t0, enb, ebits);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_random();
        test_reset_mid();
        test_back_to_back();
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
